// File: rtl/fp_mac_dot_pkg.sv
// Shared types for the floating-point dot-product controller: FSM states and rounding-mode codes.
package fp_mac_dot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [2:0] RND_NEAREST_EVEN = 3'b000;
  localparam logic [2:0] RND_TO_ZERO      = 3'b001;
  localparam logic [2:0] RND_UP           = 3'b010;
  localparam logic [2:0] RND_DOWN         = 3'b011;
  localparam logic [2:0] RND_NEAREST_UP   = 3'b100;
  localparam logic [2:0] RND_AWAY         = 3'b101;

endpackage

// File: rtl/fp_mac_dot_ctrl_mac.sv
// Combinational fused multiply-add z = a*b + c, single rounding; subnormal inputs and results flush to zero.
// Status: [0] zero, [1] infinity, [2] invalid, [3] tiny, [4] huge, [5] inexact, [7:6] unused (0).
module dw_fp_mac
  import fp_mac_dot_pkg::*;
#(
  parameter int SIG_WIDTH       = 23,
  parameter int EXP_WIDTH       = 8,
  parameter int IEEE_COMPLIANCE = 0
) (
  input  logic [SIG_WIDTH+EXP_WIDTH:0] i_a,
  input  logic [SIG_WIDTH+EXP_WIDTH:0] i_b,
  input  logic [SIG_WIDTH+EXP_WIDTH:0] i_c,
  input  logic [2:0]                   i_rnd,
  output logic [SIG_WIDTH+EXP_WIDTH:0] o_z,
  output logic [7:0]                   o_status
);

  localparam int PW  = 2*SIG_WIDTH + 2;
  localparam int SW  = PW + 4;
  localparam int NW  = SW - 1;
  localparam int LW  = $clog2(SW) + 1;
  localparam int EW2 = EXP_WIDTH + 3;
  localparam logic signed [EW2-1:0] BIAS     = EW2'((1 << (EXP_WIDTH-1)) - 1);
  localparam logic signed [EW2-1:0] EINF     = EW2'((1 << EXP_WIDTH) - 1);
  localparam logic signed [EW2-1:0] NORM_OFF = EW2'(2*SIG_WIDTH + 3);
  localparam logic signed [EW2-1:0] DMAX     = EW2'(SW);
  localparam logic signed [EW2-1:0] EONE     = EW2'(1);
  localparam logic signed [EW2-1:0] EZERO    = '0;
  localparam logic [SIG_WIDTH+EXP_WIDTH:0] NAN_Z = (IEEE_COMPLIANCE != 0) ?
    {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(SIG_WIDTH-1){1'b0}}} :
    {1'b0, {EXP_WIDTH{1'b1}}, SIG_WIDTH'(1)};

  logic                 w_sa, w_sb, w_sc;
  logic [EXP_WIDTH-1:0] w_ea, w_eb, w_ec;
  logic [SIG_WIDTH-1:0] w_fa, w_fb, w_fc;
  assign {w_sa, w_ea, w_fa} = i_a;
  assign {w_sb, w_eb, w_fb} = i_b;
  assign {w_sc, w_ec, w_fc} = i_c;

  logic w_a_zero, w_b_zero, w_c_zero, w_a_inf, w_b_inf, w_c_inf, w_any_nan;
  assign w_a_zero  = (w_ea == '0);
  assign w_b_zero  = (w_eb == '0);
  assign w_c_zero  = (w_ec == '0);
  assign w_a_inf   = (w_ea == '1) && (w_fa == '0);
  assign w_b_inf   = (w_eb == '1) && (w_fb == '0);
  assign w_c_inf   = (w_ec == '1) && (w_fc == '0);
  assign w_any_nan = ((w_ea == '1) && (w_fa != '0)) || ((w_eb == '1) && (w_fb != '0)) ||
                     ((w_ec == '1) && (w_fc != '0));

  logic                  w_ps, w_xs, w_ys, w_rs, w_stk, w_g, w_st, w_inc, w_ovf_max;
  logic [PW-1:0]         w_pm, w_cm, w_xm, w_ym;
  logic signed [EW2-1:0] w_pe, w_ce, w_emax, w_d, w_er, w_erf;
  logic [SW-1:0]         w_xw, w_yw, w_ysh, w_sum;
  logic [NW-1:0]         w_norm;
  logic [LW-1:0]         w_amt, w_lead;
  logic [SIG_WIDTH-1:0]  w_frac, w_fr;
  logic [SIG_WIDTH+1:0]  w_mr;

  // Alignment, add, normalise and round on a common fixed-point grid with 3 guard bits.
  always_comb begin
    w_ps   = w_sa ^ w_sb;
    w_pm   = PW'({1'b1, w_fa}) * PW'({1'b1, w_fb});
    w_cm   = w_c_zero ? '0 : PW'({1'b1, w_fc, {SIG_WIDTH{1'b0}}});
    w_pe   = EW2'(w_ea) + EW2'(w_eb) - BIAS;
    w_ce   = EW2'(w_ec);
    if (w_c_zero || (w_pe >= w_ce)) begin
      w_xm = w_pm; w_xs = w_ps; w_emax = w_pe; w_ym = w_cm; w_ys = w_sc; w_d = w_pe - w_ce;
    end else begin
      w_xm = w_cm; w_xs = w_sc; w_emax = w_ce; w_ym = w_pm; w_ys = w_ps; w_d = w_ce - w_pe;
    end
    w_xw  = {1'b0, w_xm, 3'b000};
    w_yw  = {1'b0, w_ym, 3'b000};
    w_amt = w_d[LW-1:0];
    if (w_d >= DMAX) begin
      w_ysh = '0;
      w_stk = |w_yw;
    end else begin
      w_ysh = w_yw >> w_amt;
      w_stk = |(w_yw & ~({SW{1'b1}} << w_amt));
    end
    w_ysh[0] = w_ysh[0] | w_stk;
    if (w_xs == w_ys) begin
      w_sum = w_xw + w_ysh; w_rs = w_xs;
    end else if (w_xw >= w_ysh) begin
      w_sum = w_xw - w_ysh; w_rs = w_xs;
    end else begin
      w_sum = w_ysh - w_xw; w_rs = w_ys;
    end
    w_lead = '0;
    for (int i = 0; i < SW; i++) begin
      if (w_sum[i]) w_lead = LW'(i);
    end
    w_er   = w_emax + EW2'(w_lead) - NORM_OFF;
    w_norm = NW'(w_sum << (LW'(SW-1) - w_lead));
    w_frac = w_norm[NW-1 -: SIG_WIDTH];
    w_g    = w_norm[NW-1-SIG_WIDTH];
    w_st   = |w_norm[NW-2-SIG_WIDTH:0];
    case (i_rnd)
      RND_TO_ZERO:    w_inc = 1'b0;
      RND_UP:         w_inc = !w_rs && (w_g || w_st);
      RND_DOWN:       w_inc = w_rs && (w_g || w_st);
      RND_NEAREST_UP: w_inc = w_g;
      RND_AWAY:       w_inc = w_g || w_st;
      default:        w_inc = w_g && (w_st || w_frac[0]);
    endcase
    w_mr = {2'b01, w_frac} + (SIG_WIDTH+2)'(w_inc);
    if (w_mr[SIG_WIDTH+1]) begin
      w_fr = w_mr[SIG_WIDTH:1]; w_erf = w_er + EONE;
    end else begin
      w_fr = w_mr[SIG_WIDTH-1:0]; w_erf = w_er;
    end
    w_ovf_max = (i_rnd == RND_TO_ZERO) || ((i_rnd == RND_UP) && w_rs) ||
                ((i_rnd == RND_DOWN) && !w_rs);
  end

  always_comb begin
    o_z      = '0;
    o_status = '0;
    if (w_any_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero) ||
        ((w_a_inf || w_b_inf) && w_c_inf && (w_ps != w_sc))) begin
      o_z         = NAN_Z;
      o_status[2] = 1'b1;
    end else if (w_a_inf || w_b_inf) begin
      o_z         = {w_ps, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
      o_status[1] = 1'b1;
    end else if (w_c_inf) begin
      o_z         = {w_sc, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
      o_status[1] = 1'b1;
    end else if (w_a_zero || w_b_zero) begin
      if (w_c_zero) begin
        o_z         = {w_ps && w_sc, {(SIG_WIDTH+EXP_WIDTH){1'b0}}};
        o_status[0] = 1'b1;
      end else begin
        o_z = i_c;
      end
    end else if (w_sum == '0) begin
      o_status[0] = 1'b1;
    end else if (w_erf >= EINF) begin
      o_status[4] = 1'b1;
      o_status[5] = 1'b1;
      if (w_ovf_max) begin
        o_z = {w_rs, {(EXP_WIDTH-1){1'b1}}, 1'b0, {SIG_WIDTH{1'b1}}};
      end else begin
        o_z         = {w_rs, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
        o_status[1] = 1'b1;
      end
    end else if (w_erf <= EZERO) begin
      o_z         = {w_rs, {(SIG_WIDTH+EXP_WIDTH){1'b0}}};
      o_status[0] = 1'b1;
      o_status[3] = 1'b1;
      o_status[5] = 1'b1;
    end else begin
      o_z         = {w_rs, w_erf[EXP_WIDTH-1:0], w_fr};
      o_status[5] = w_g || w_st;
    end
  end

endmodule

// File: rtl/fp_mac_dot_ctrl.sv
// Dot-product sequencer around a zero-latency FP MAC: one operand pair per clock into a registered accumulator.
// Optional sticky status register built only with `define FP_MAC_DOT_CTRL_STATUS_EN.
//   state    | meaning
//   ST_IDLE  | waiting for start; job registers loaded on accept
//   ST_ACCUM | accepting pairs, acc <= acc + a*b, cnt counts down
//   ST_DONE  | result valid, held until out_ready
module fp_mac_dot_ctrl
  import fp_mac_dot_pkg::*;
#(
  parameter int SIG_WIDTH       = 23,
  parameter int EXP_WIDTH       = 8,
  parameter int IEEE_COMPLIANCE = 0,
  parameter int LEN_WIDTH       = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [LEN_WIDTH-1:0]         len,
  input  logic [SIG_WIDTH+EXP_WIDTH:0] init_c,
  input  logic [2:0]                   rnd,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SIG_WIDTH+EXP_WIDTH:0] in_a,
  input  logic [SIG_WIDTH+EXP_WIDTH:0] in_b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SIG_WIDTH+EXP_WIDTH:0] out_z,
  output logic [7:0]                   out_status,
  output logic                         busy
);

  localparam int W = SIG_WIDTH + EXP_WIDTH + 1;
  localparam logic [LEN_WIDTH-1:0] CNT_ONE = LEN_WIDTH'(1);

  state_t               r_state, w_state_nxt;
  logic [W-1:0]         r_acc;
  logic [LEN_WIDTH-1:0] r_cnt;
  logic [2:0]           r_rnd;
  logic [W-1:0]         w_mac_z;
  logic [7:0]           w_mac_status;
  logic                 w_in_ready, w_out_valid, w_accept, w_xfer;

  dw_fp_mac #(
    .SIG_WIDTH      (SIG_WIDTH),
    .EXP_WIDTH      (EXP_WIDTH),
    .IEEE_COMPLIANCE(IEEE_COMPLIANCE)
  ) u_mac (
    .i_a     (in_a),
    .i_b     (in_b),
    .i_c     (r_acc),
    .i_rnd   (r_rnd),
    .o_z     (w_mac_z),
    .o_status(w_mac_status)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = (len == '0) ? ST_DONE : ST_ACCUM;
      end
      ST_ACCUM: begin
        w_in_ready = 1'b1;
        if (in_valid && (r_cnt == CNT_ONE)) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_accept  = (r_state == ST_IDLE) && start;
  assign w_xfer    = w_in_ready && in_valid;
  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_z     = r_acc;
  assign busy      = (r_state != ST_IDLE);

  // cnt only decrements on a transfer in ACCUM, where it is always >= 1, so it cannot wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_rnd <= '0;
    end else if (w_accept) begin
      r_acc <= init_c;
      r_cnt <= len;
      r_rnd <= rnd;
    end else if (w_xfer) begin
      r_acc <= w_mac_z;
      r_cnt <= r_cnt - CNT_ONE;
    end
  end

`ifdef FP_MAC_DOT_CTRL_STATUS_EN
  logic [7:0] r_status;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_status <= '0;
    end else if (w_accept) begin
      r_status <= '0;
    end else if (w_xfer) begin
      r_status <= {r_status[7:1] | w_mac_status[7:1], w_mac_status[0]};
    end
  end

  assign out_status = r_status;
`else
  logic w_status_unused;
  assign w_status_unused = ^w_mac_status;
  assign out_status      = '0;
`endif

endmodule
